// File: rtl/sample_capture_fifo.sv
// sample_capture_fifo: captures sample_data on each rising edge of sample_tick
// (while enabled) into a small FIFO. A Nios master drains the FIFO and reads
// status and control over a zero-latency Avalon-MM slave. A level interrupt
// fires on fill threshold or overflow.
module sample_capture_fifo #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              read_n,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic              sample_tick,
   input  logic [DATA_W-1:0] sample_data,
   output logic              irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;

   logic                  tick_prev;
   logic                  enable;
   logic                  irq_en;
   logic [4:0]            threshold;
   logic                  overflow;
   logic [7:0]            drop_cnt;

   logic                  rd_sel;
   logic                  wr_sel;
   logic                  ctrl_wr;
   logic                  flush;
   logic                  clear;
   logic                  tick_edge;
   logic                  empty;
   logic                  full;
   logic                  pop;
   logic                  push_req;
   logic                  push_ok;
   logic                  drop;
   logic [31:0]           status;
   logic [31:0]           ctrl_rd;
   logic [8:0]            count_ext;
   logic [8:0]            thr_ext;
   logic                  unused_wdata;

   assign rd_sel    = chipselect & ~read_n;
   assign wr_sel    = chipselect & ~write_n;
   assign ctrl_wr   = wr_sel & (address == 2'd2);
   assign flush     = ctrl_wr & writedata[2];
   assign clear     = ctrl_wr & writedata[3];

   assign tick_edge = sample_tick & ~tick_prev;
   assign empty     = (count == '0);
   assign full      = (count == COUNT_FULL);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
   // that coincides with a read. Flush wins over both and suppresses overflow.
   assign pop       = rd_sel & (address == 2'd0) & ~empty;
   assign push_req  = tick_edge & enable;
   assign push_ok   = push_req & (~full | pop) & ~flush;
   assign drop      = push_req & full & ~pop & ~flush;

   assign count_ext = 9'(count);
   assign thr_ext   = 9'(threshold);
   assign irq       = (irq_en & (threshold != 5'd0) & (count_ext >= thr_ext))
                    | (irq_en & overflow);

   assign unused_wdata = ^{writedata[31:13], writedata[7:4]};

   // Edge detector history; runs regardless of enable so that enabling while
   // the strobe is already high does not look like a fresh edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tick_prev <= 1'b0;
      else          tick_prev <= sample_tick;
   end

   // Control register; a push in the write cycle still sees the old enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable    <= 1'b0;
         irq_en    <= 1'b0;
         threshold <= 5'd0;
      end else if (ctrl_wr) begin
         enable    <= writedata[0];
         irq_en    <= writedata[1];
         threshold <= writedata[12:8];
      end
   end

   // Sample storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= sample_data;
   end

   // Pointers and fill level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Overflow bookkeeping; a new drop outranks a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clear)                 drop_cnt <= 8'd1;
         else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (clear) begin
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end
   end

   // Status and control read images.
   always_comb begin
      status                 = '0;
      status[DEPTH_LOG2:0]   = count;
      status[23:16]          = drop_cnt;
      status[24]             = empty;
      status[25]             = full;
      status[26]             = overflow;
      ctrl_rd                = '0;
      ctrl_rd[0]             = enable;
      ctrl_rd[1]             = irq_en;
      ctrl_rd[12:8]          = threshold;
   end

   // Zero-latency read mux, driven only while a read is strobed.
   always_comb begin
      readdata = '0;
      if (rd_sel) begin
         case (address)
            2'd0:    if (!empty) readdata = 32'(mem[rd_ptr]);
            2'd1:    readdata = status;
            2'd2:    readdata = ctrl_rd;
            default: readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_capture_fifo.sv
// Bench for sample_capture_fifo: directed scenarios followed by a random
// phase, all checked against a queue-based reference model.
module tb_sample_capture_fifo;

   localparam int DATA_W     = 16;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 16;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        sample_tick;
   logic [15:0] sample_data;
   logic        irq;

   int vectors;
   int miscompares;

   // reference model state
   logic [15:0] q[$];
   logic        m_prev;
   logic        m_en;
   logic        m_irqen;
   logic [4:0]  m_thr;
   logic        m_ovf;
   int          m_drop;
   logic        tick_hold;

   sample_capture_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .sample_tick(sample_tick), .sample_data(sample_data),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_prev  = 1'b0;
      m_en    = 1'b0;
      m_irqen = 1'b0;
      m_thr   = 5'd0;
      m_ovf   = 1'b0;
      m_drop  = 0;
   endtask

   function automatic logic m_irq();
      return m_irqen && ((m_thr != 0 && q.size() >= int'(m_thr)) || m_ovf);
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0: if (q.size() != 0) r = {16'h0, q[0]};
         2'd1: begin
            r[15:0]  = 16'(q.size());
            r[23:16] = 8'(m_drop);
            r[24]    = (q.size() == 0);
            r[25]    = (q.size() == DEPTH);
            r[26]    = m_ovf;
         end
         2'd2: begin
            r[0]    = m_en;
            r[1]    = m_irqen;
            r[12:8] = m_thr;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic model_clk(input logic tick, input logic [15:0] d, input logic rd,
                            input logic wr, input logic [1:0] a, input logic [31:0] wd);
      logic rise, do_flush, do_clear, do_pop, do_push, dropped;
      rise     = tick && !m_prev;
      m_prev   = tick;
      do_flush = wr && a == 2'd2 && wd[2];
      do_clear = wr && a == 2'd2 && wd[3];
      do_pop   = rd && a == 2'd0 && q.size() != 0;
      do_push  = rise && m_en;
      dropped  = 1'b0;
      if (do_flush) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            if (q.size() < DEPTH) q.push_back(d);
            else dropped = 1'b1;
         end
      end
      if (dropped) begin
         m_ovf  = 1'b1;
         m_drop = do_clear ? 1 : (m_drop >= 255 ? 255 : m_drop + 1);
      end else if (do_clear) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      if (wr && a == 2'd2) begin
         m_en    = wd[0];
         m_irqen = wd[1];
         m_thr   = wd[12:8];
      end
   endtask

   // One bus cycle: drive, check read data mid-cycle, clock, check irq.
   task automatic step(input logic tick, input logic [15:0] d, input logic rd,
                       input logic wr, input logic [1:0] a, input logic [31:0] wd);
      sample_tick = tick;
      sample_data = d;
      chipselect  = rd | wr;
      read_n      = ~rd;
      write_n     = ~wr;
      address     = a;
      writedata   = wd;
      @(negedge clk);
      if (rd) check($sformatf("read_a%0d", a), readdata, m_read(a));
      @(posedge clk);
      model_clk(tick, d, rd, wr, a, wd);
      #1;
      check("irq", {31'b0, irq}, {31'b0, m_irq()});
   endtask

   task automatic pulse(input logic [15:0] d);
      step(1'b1, d, 1'b0, 1'b0, 2'd0, 32'h0);
      step(1'b0, d, 1'b0, 1'b0, 2'd0, 32'h0);
   endtask

   task automatic rd(input logic [1:0] a);
      step(tick_hold, 16'h0, 1'b1, 1'b0, a, 32'h0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] wd);
      step(tick_hold, 16'h0, 1'b0, 1'b1, a, wd);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      tick_hold   = 1'b0;
      model_reset();
      reset_n     = 1'b0;
      address     = 2'd0;
      chipselect  = 1'b0;
      read_n      = 1'b1;
      write_n     = 1'b1;
      writedata   = 32'h0;
      sample_tick = 1'b0;
      sample_data = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_rdata", readdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // basic capture and drain
      rd(2'd1);
      wr(2'd2, 32'h1);
      pulse(16'h0011);
      pulse(16'h0022);
      pulse(16'h0033);
      rd(2'd1);
      check("count3", readdata, 32'h0000_0003);
      rd(2'd0);
      rd(2'd0);
      rd(2'd0);
      rd(2'd0);
      rd(2'd1);

      // overflow by two, then clear
      for (int i = 0; i < 18; i++) pulse(16'(i + 16'h100));
      rd(2'd1);
      check("ovf_status", readdata, 32'h0602_0010);
      wr(2'd2, 32'h9);
      rd(2'd1);

      // full FIFO: read coincides with edge, push accepted without overflow
      step(1'b1, 16'hABCD, 1'b1, 1'b0, 2'd0, 32'h0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 32'h0);
      rd(2'd1);
      for (int i = 0; i < 16; i++) rd(2'd0);
      rd(2'd1);

      // threshold interrupt
      wr(2'd2, 32'h0000_0403);
      for (int i = 0; i < 3; i++) pulse(16'(i + 16'h40));
      step(1'b1, 16'h0044, 1'b0, 1'b0, 2'd0, 32'h0);
      check("irq_at_thr", {31'b0, irq}, 32'h1);
      step(1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 32'h0);
      rd(2'd0);
      check("irq_after_pop", {31'b0, irq}, 32'h0);

      // enable while tick already high does not push
      wr(2'd2, 32'h4);
      tick_hold = 1'b1;
      rd(2'd1);
      wr(2'd2, 32'h1);
      rd(2'd1);
      rd(2'd1);
      tick_hold = 1'b0;
      rd(2'd1);
      pulse(16'h0777);
      rd(2'd1);
      // flush in the same cycle as an edge
      step(1'b1, 16'h0888, 1'b0, 1'b1, 2'd2, 32'h5);
      step(1'b0, 16'h0, 1'b1, 1'b0, 2'd1, 32'h0);
      // flush while full and an edge arrives
      for (int i = 0; i < 16; i++) pulse(16'(i));
      step(1'b1, 16'h0999, 1'b0, 1'b1, 2'd2, 32'h5);
      step(1'b0, 16'h0, 1'b1, 1'b0, 2'd1, 32'h0);

      // drop counter saturation, then drop coinciding with clear
      for (int i = 0; i < 16; i++) pulse(16'(i));
      for (int i = 0; i < 260; i++) pulse(16'h0EEE);
      rd(2'd1);
      check("drop_sat", readdata, 32'h06FF_0010);
      step(1'b1, 16'h0AAA, 1'b0, 1'b1, 2'd2, 32'h9);
      step(1'b0, 16'h0, 1'b1, 1'b0, 2'd1, 32'h0);

      // asynchronous reset mid-operation
      wr(2'd2, 32'h0000_0507);
      for (int i = 0; i < 5; i++) pulse(16'(i + 16'h50));
      chipselect = 1'b0;
      read_n     = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async_irq", {31'b0, irq}, 32'h0);
      check("async_rdata_idle", readdata, 32'h0);
      chipselect = 1'b1;
      read_n     = 1'b0;
      address    = 2'd2;
      #1;
      check("async_ctrl", readdata, 32'h0);
      address = 2'd0;
      #1;
      check("async_head", readdata, 32'h0);
      address = 2'd1;
      #1;
      check("async_status", readdata, 32'h0100_0000);
      chipselect = 1'b0;
      read_n     = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) pulse(16'(i + 16'h60));
      rd(2'd1);
      check("no_push_after_rst", readdata, 32'h0100_0000);
      wr(2'd2, 32'h1);
      pulse(16'h0061);
      rd(2'd1);

      // random phase
      for (int i = 0; i < 600; i++) begin
         int sel;
         logic [31:0] wd;
         sel = int'($urandom_range(0, 99));
         if (sel < 40) begin
            step(1'($urandom), 16'($urandom), 1'b0, 1'b0, 2'd0, 32'h0);
         end else if (sel < 85) begin
            step(1'($urandom), 16'($urandom), 1'b1, 1'b0, 2'($urandom), 32'h0);
         end else begin
            wd        = $urandom;
            wd[0]     = ($urandom_range(0, 3) != 0);
            wd[2]     = ($urandom_range(0, 5) == 0);
            wd[3]     = ($urandom_range(0, 3) == 0);
            wd[12:8]  = 5'($urandom_range(0, 17));
            step(1'($urandom), 16'($urandom), 1'b0, 1'b1,
                 ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'd2, wd);
         end
      end
      rd(2'd1);
      rd(2'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sample_capture_fifo.md
# sample_capture_fifo

Downstream consumer of the software-driven sample-clock PIO strobe. Each rising edge of `sample_tick` while enabled captures `sample_data` into an on-chip FIFO. The Nios processor drains the FIFO and reads its status over an Avalon-MM slave. An interrupt fires when the fill level reaches a programmable threshold.

## Interface
- `DATA_W`, 16: width of the captured sample, 1..32.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries, 2..8.
- `clk`, in, 1: system clock. All logic is on this edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `address`, in, 2: Avalon register select.
- `chipselect`, in, 1: Avalon slave select.
- `read_n`, in, 1: Avalon read strobe, active-low.
- `write_n`, in, 1: Avalon write strobe, active-low.
- `writedata`, in, 32: Avalon write data.
- `readdata`, out, 32: Avalon read data. Read latency 0, no waitrequest.
- `sample_tick`, in, 1: sample strobe from the sample-clock PIO `out_port`. Synchronous to `clk`.
- `sample_data`, in, DATA_W: sample source, sampled on the capture edge.
- `irq`, out, 1: level interrupt, active-high.

## Operation
- Edge detect:
  - `tick_prev` register, reset 0, updated every cycle regardless of enable.
  - `edge = sample_tick & ~tick_prev`.
  - Enabling while `sample_tick` is already high does not create an edge.
- Push: `edge & enable`.
  - If count < DEPTH, or a pop occurs in the same cycle, write `sample_data` at the write pointer and advance it.
  - Otherwise drop the sample, set sticky `overflow`, and increment `drop_cnt` (8-bit, saturates at 255).
- Pop: `chipselect & ~read_n & address==0 & count!=0`. Advances the read pointer.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. `count` is DEPTH_LOG2+1 bits, 0..DEPTH.
- Simultaneous push and pop: both happen and count is unchanged. This also applies when full: the push is accepted and there is no overflow.
- Register map:
  - Addr 0 read: head sample zero-extended to 32 bits, then pop. When empty: reads 0 with no state change.
  - Addr 0 write: ignored.
  - Addr 1 read, status:
    - [DEPTH_LOG2:0] count
    - [24] empty
    - [25] full
    - [26] overflow
    - [23:16] drop_cnt
    - other bits 0
  - Addr 1 write: ignored.
  - Addr 2 read/write, control:
    - [0] enable
    - [1] irq_en
    - [12:8] threshold (5 bits)
    - Reads return the stored fields; bits [3:2] read 0.
  - Addr 2 write bit [2] = flush, self-clearing: pointers and count go to 0.
  - Addr 2 write bit [3] = clear: overflow and drop_cnt go to 0.
  - Addr 3: reads 0, writes ignored.
- Priority:
  - Flush beats a same-cycle push or pop: the sample is discarded and overflow is not set.
  - A new overflow beats a same-cycle clear: overflow ends at 1 and drop_cnt at 1.
- `irq = irq_en & (threshold != 0) & (count >= threshold) | irq_en & overflow`.
- Reset values:
  - enable, irq_en, threshold, overflow, drop_cnt, count, pointers, `tick_prev`: all 0.
  - `irq` = 0; `readdata` = 0.
  - FIFO storage is not reset.

## Timing
- Capture: `sample_tick` goes 0→1 before edge N. `sample_data` is latched at edge N, and count/status reflect it after edge N.
- The sample is readable from addr 0 in the cycle after edge N.
- `readdata` is combinational from registered state and `address`; it is valid in the same cycle as the read strobe.
- The pop commits at the clock edge ending the read cycle.
- Back-to-back reads on consecutive cycles return consecutive FIFO entries.
- A control write takes effect at the edge ending the write cycle. A push in that same cycle uses the old enable.
- `irq` is combinational from registers, so it changes in the cycle after the causing edge. No extra pipeline.
- Reset asserted mid-operation: all state clears immediately (asynchronously). There are no pushes until reset is released and enable is rewritten.
- Minimum `sample_tick` period is 2 cycles (high 1, low 1). A tick held high for many cycles produces exactly one push.

## Test plan
- Reset, write ctrl=0x1, drive 3 ticks with data 0x0011/0x0022/0x0033 → status count=3; addr 0 reads 0x11, 0x22, 0x33, then 0; empty=1.
- DEPTH=16: 18 ticks → count=16, full=1, overflow=1, drop_cnt=2. Write ctrl bit3 → overflow=0, drop_cnt=0, count stays 16.
- Full FIFO, addr 0 read in the same cycle as a tick edge → count stays 16, overflow stays 0, and the new sample ends up at the tail after wrap.
- ctrl=0x0403 (enable, irq_en, threshold=4): irq stays 0 at count 3. irq=1 the cycle after the 4th push, and 0 after one pop.
- `sample_tick` held high while writing enable=1 → no push. The next 0→1 pushes exactly one sample. A flush write in the same cycle as an edge → count=0, overflow=0.
- Assert reset_n=0 with count=5 and enable=1 → count, irq, ctrl and readdata are all 0 immediately. After release, ticks push nothing until enable is rewritten.
